sram_port_arbiter: RTL

Shares the calculator's two-SRAM memory (64-bit words split across two 32x512 macros, write on port 0, read on port 1) between two requesters: requester 0 is the calculator controller and requester 1 is the host/debug loader. The block arbitrates the write channel and the read channel independently each cycle, using round-robin with a bounded burst lock. It tracks the one-cycle SRAM read latency so each read response is steered to its issuer. It sits between the requesters and the SRAM pair in `top_lvl`.

---
 rtl/calculator_pkg.sv | 18 +
 rtl/rr_lock_arb.sv | 70 +++++++
 rtl/sram_port_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/calculator_pkg.sv
// Shared calculator definitions: memory geometry, requester count and the
// per-requester memory request bundle used by the SRAM port arbiter.
package calculator_pkg;

  localparam int ADDR_W           = 9;
  localparam int MEM_WORD_SIZE    = 64;
  localparam int NUM_REQ          = 2;
  localparam int LOCK_MAX_DEFAULT = 16;

  typedef struct packed {
    logic                     req;
    logic                     we;
    logic                     lock;
    logic [ADDR_W-1:0]        addr;
    logic [MEM_WORD_SIZE-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_lock_arb.sv
// Two-input round-robin arbiter with a bounded burst lock, one per SRAM channel.
//   clk_i, rst_i : clock, async active-low reset
//   cand_i       : candidates on this channel
//   lock_i       : per-requester lock request
//   hold_i       : caller withheld this cycle's grant; no pointer/lock update
//   gnt_o        : tentative one-hot grant (before any hold by the caller)
//   gnt_id_o     : index of the tentative winner
module rr_lock_arb
  import calculator_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] cand_i,
  input  logic [1:0] lock_i,
  input  logic       hold_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             last_q, last_d;
  logic             prev_q, prev_d;   // a grant was issued last cycle
  logic [CNT_W-1:0] cnt_q, cnt_d;     // consecutive grants held against a waiter
  logic             keep;
  logic             gid;
  logic             any;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b1;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    any  = |cand_i;
    // Holder keeps the channel unless it has used up its burst while the other waits.
    keep = prev_q && cand_i[last_q] && lock_i[last_q] &&
           !(cand_i[~last_q] && (cnt_q >= CNT_W'(LOCK_MAX)));
    if (keep)          gid = last_q;
    else if (&cand_i)  gid = ~last_q;
    else               gid = cand_i[1];
    gnt_o    = 2'b00;
    gnt_o[0] = any && !gid;
    gnt_o[1] = any && gid;
    gnt_id_o = gid;
  end

  always_comb begin
    last_d = last_q;
    prev_d = 1'b0;
    cnt_d  = '0;
    if (any && !hold_i) begin
      last_d = gid;
      prev_d = 1'b1;
      // The first grant of a run counts as one; runs only accrue while the other waits.
      if (lock_i[gid] && cand_i[~gid])
        cnt_d = (prev_q && (gid == last_q)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the two-macro calculator SRAM (write port 0, read port 1) between the
// calculator controller (requester 0) and the host/debug loader (requester 1).
//   clk_i, rst_i            : clock, async active-low reset
//   req_i/we_i/lock_i       : per-requester request, write select, burst lock
//   addr_i/wdata_i          : per-requester word address and write data
//   gnt_o                   : combinational accept per requester
//   rvalid_o/rdata_o        : read response, one cycle after read grant
//   mem_write_o/_w_addr/_w_data : SRAM write port
//   mem_read_o/_r_addr, mem_r_data_i : SRAM read port
module sram_port_arbiter #(
  parameter int ADDR_W   = calculator_pkg::ADDR_W,
  parameter int DATA_W   = calculator_pkg::MEM_WORD_SIZE,
  parameter int LOCK_MAX = calculator_pkg::LOCK_MAX_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0]             lock_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   mem_write_o,
  output logic [ADDR_W-1:0]      mem_w_addr_o,
  output logic [DATA_W-1:0]      mem_w_data_o,
  output logic                   mem_read_o,
  output logic [ADDR_W-1:0]      mem_r_addr_o,
  input  logic [DATA_W-1:0]      mem_r_data_i
);

  logic [1:0] w_cand, r_cand;
  logic [1:0] w_win, r_win, r_gnt;
  logic       w_id, r_id;
  logic       hazard;
  logic       rvld_q, rvld_d;
  logic       rown_q, rown_d;

  assign w_cand = req_i & we_i;
  assign r_cand = req_i & ~we_i;

  rr_lock_arb #(.LOCK_MAX(LOCK_MAX)) u_w_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cand_i   (w_cand),
    .lock_i   (lock_i),
    .hold_i   (1'b0),
    .gnt_o    (w_win),
    .gnt_id_o (w_id)
  );

  rr_lock_arb #(.LOCK_MAX(LOCK_MAX)) u_r_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cand_i   (r_cand),
    .lock_i   (lock_i),
    .hold_i   (hazard),
    .gnt_o    (r_win),
    .gnt_id_o (r_id)
  );

  // A read racing a write to the same word from the other requester waits a cycle
  // so it observes the new data.
  assign hazard = (|w_win) && (|r_win) && (w_id != r_id) && (addr_i[w_id] == addr_i[r_id]);
  assign r_gnt  = hazard ? 2'b00 : r_win;

  // Strobes and grants are forced low while reset is held, independent of inputs.
  assign gnt_o        = {2{rst_i}} & (w_win | r_gnt);
  assign mem_write_o  = rst_i & (|w_win);
  assign mem_w_addr_o = mem_write_o ? addr_i[w_id]  : '0;
  assign mem_w_data_o = mem_write_o ? wdata_i[w_id] : '0;
  assign mem_read_o   = rst_i & (|r_gnt);
  assign mem_r_addr_o = mem_read_o ? addr_i[r_id] : '0;
  assign rdata_o      = mem_r_data_i;

  always_comb begin
    rvld_d = |r_gnt;
    rown_d = r_id;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rvld_q <= 1'b0;
      rown_q <= 1'b0;
    end else begin
      rvld_q <= rvld_d;
      rown_q <= rown_d;
    end
  end

  always_comb begin
    rvalid_o = 2'b00;
    if (rvld_q) rvalid_o[rown_q] = 1'b1;
  end

endmodule
